// File: rtl/frame_deser_pkg.sv
// Shared types and defaults for the frame deserializer slice.
package frame_deser_pkg;

  localparam int BITS_PER_FRAME_DEF = 256;
  localparam int FIFO_AW_DEF        = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  typedef struct packed {
    logic       sof;
    logic [7:0] data;
  } fifo_word_t;

  // Bit counter must hold BITS_PER_FRAME itself, so one bit wider than log2.
  function automatic int cnt_width(input int bits_per_frame);
    return $clog2(bits_per_frame) + 1;
  endfunction

endpackage

// File: rtl/frame_deser_if.sv
// Valid/ready byte stream from the deserializer to the packet layer.
interface frame_deser_if;
  logic [7:0] out_data;
  logic       out_sof;
  logic       out_valid;
  logic       out_ready;

  modport master (output out_data, output out_sof, output out_valid, input out_ready);
  modport slave  (input out_data, input out_sof, input out_valid, output out_ready);
endinterface

// File: rtl/frame_deser_sync_fifo.sv
// First-word-fall-through FIFO; a push into a full FIFO is accepted only if a pop frees space the same cycle.
module frame_deser_sync_fifo #(
  parameter int WIDTH = 9,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             drop
);
  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop;
  assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer update; extra MSB distinguishes full from empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since empty masks the read port.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/frame_deser.sv
// Serial-to-byte deserializer behind the dpll: frame alignment on wc, length check, byte FIFO.
//
//  state | meaning
//  IDLE  | not aligned; waiting for locked & wc rising edge
//  RUN   | inside a frame, shifting one bit per bitclock strobe
//  DROP  | frame overran its length; ignoring strobes until next wc
module frame_deser
  import frame_deser_pkg::*;
#(
  parameter int BITS_PER_FRAME = BITS_PER_FRAME_DEF,
  parameter int FIFO_AW        = FIFO_AW_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wc,
  input  logic                 bitclock,
  input  logic                 locked,
  input  logic                 sdata,
  frame_deser_if.master        bus,
  output logic                 frame_err,
  output logic                 overflow
);
  localparam int CNT_W = cnt_width(BITS_PER_FRAME);

  state_t           state;
  state_t           next_state;
  logic             wc_d;
  logic             bc_d;
  logic             wc_rise;
  logic             strobe;
  logic [CNT_W-1:0] bitcnt;
  logic [6:0]       shreg;
  logic             frame_full;
  logic             start_frame;
  logic             shift_en;
  logic             push_c;
  logic             err_c;
  logic             push_q;
  fifo_word_t       push_word;
  fifo_word_t       rd_word;
  logic             fifo_empty;
  logic             fifo_drop;
  logic             pop;

  assign wc_rise    = wc & ~wc_d;
  assign strobe     = bitclock & ~bc_d;
  assign frame_full = (bitcnt == CNT_W'(BITS_PER_FRAME));

  // Delay registers for wc / bitclock rising-edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      wc_d <= 1'b0;
      bc_d <= 1'b0;
    end else begin
      wc_d <= wc;
      bc_d <= bitclock;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Next state: loss of lock dominates, then a new frame start, then overrun.
  always_comb begin
    next_state = state;
    if (!locked)                                           next_state = ST_IDLE;
    else if (wc_rise)                                      next_state = ST_RUN;
    else if (state == ST_RUN && strobe && frame_full)      next_state = ST_DROP;
  end

  // FSM outputs; a strobe coinciding with wc_rise becomes bit 0 of the new frame.
  always_comb begin
    start_frame = locked & wc_rise;
    shift_en    = locked & strobe & (start_frame | ((state == ST_RUN) & ~frame_full));
    push_c      = shift_en & ~start_frame & (bitcnt[2:0] == 3'd7);
    err_c       = locked & (state == ST_RUN) & (wc_rise ? ~frame_full : (strobe & frame_full));
  end

  // Bit counter, shift register, registered byte push and error pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      bitcnt    <= '0;
      shreg     <= '0;
      push_q    <= 1'b0;
      push_word <= '0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      frame_err <= err_c;
      overflow  <= fifo_drop;
      push_q    <= push_c;
      push_word <= {(bitcnt[CNT_W-1:3] == '0), shreg, sdata};
      if (start_frame) begin
        bitcnt <= strobe ? CNT_W'(1) : '0;
        shreg  <= {6'b0, sdata & strobe};
      end else if (shift_en) begin
        bitcnt <= bitcnt + CNT_W'(1);
        shreg  <= {shreg[5:0], sdata};
      end else if (!locked) begin
        bitcnt <= '0;
        shreg  <= '0;
      end
    end
  end

  assign pop           = bus.out_valid & bus.out_ready;
  assign bus.out_valid = ~fifo_empty;
  assign bus.out_data  = rd_word.data;
  assign bus.out_sof   = rd_word.sof;

  frame_deser_sync_fifo #(
    .WIDTH ($bits(fifo_word_t)),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_q),
    .wdata (push_word),
    .pop   (pop),
    .rdata (rd_word),
    .empty (fifo_empty),
    .drop  (fifo_drop)
  );

endmodule
